// File: rtl/oh_clkmon.sv
// oh_clkmon: clock activity monitor for the far end of a clock buffer tree.
//
// The monitored clock (mon_clk) is sampled as asynchronous data in the
// reference domain (clk). Its rising edges are counted over a programmable
// window. Each completed window is classified as ok, slow or fast. Slow and
// fast results set sticky error flags, and those flags raise an interrupt.
//
// Optional feature (macro OH_CLKMON_STUCK_EN): stuck-level detection. When the
// synchronized mon_clk holds one level for 2^WINDOW_W-1 cycles while enabled,
// clk_stuck is set. Without the macro, clk_stuck is tied to 0.
//
// Parameters:
//   WINDOW_W    width of the window length counter
//   CNT_W       width of the edge counter and the thresholds
//   SYNC_STAGES synchronizer depth on mon_clk (2..4)
//
// Ports:
//   clk, nreset          reference clock, asynchronous active-low reset
//   en                   monitor enable
//   mon_clk              monitored clock (asynchronous, must be < clk/2)
//   win_len              window length in clk cycles (0 behaves as 1)
//   min_edges/max_edges  accepted edge-count range per window
//   clear                clears the sticky flags and irq
//   edge_count, valid    count of the last window, one-cycle update pulse
//   clk_ok               last window was inside [min_edges, max_edges]
//   slow_err, fast_err   sticky range violations
//   clk_stuck            sticky stuck-level detect
//   irq                  registered OR of the sticky flags
module oh_clkmon #(
   parameter int WINDOW_W    = 8,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                en,
   input  logic                mon_clk,
   input  logic [WINDOW_W-1:0] win_len,
   input  logic [CNT_W-1:0]    min_edges,
   input  logic [CNT_W-1:0]    max_edges,
   input  logic                clear,
   output logic [CNT_W-1:0]    edge_count,
   output logic                valid,
   output logic                clk_ok,
   output logic                slow_err,
   output logic                fast_err,
   output logic                clk_stuck,
   output logic                irq
);

   typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, REPORT = 2'd2} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                  sync_out;
   logic                  sync_prev;
   logic                  rise;
   logic [WINDOW_W-1:0]   win_cnt;
   logic [WINDOW_W-1:0]   win_cnt_nxt;
   logic [WINDOW_W-1:0]   win_load;
   logic [CNT_W-1:0]      edge_cnt;
   logic [CNT_W-1:0]      edge_cnt_nxt;
   logic [CNT_W-1:0]      edge_inc;
   logic [CNT_W-1:0]      min_lat;
   logic [CNT_W-1:0]      max_lat;
   logic                  load_cfg;
   logic                  report;
   logic                  is_slow;
   logic                  is_fast;

   assign sync_out = sync[SYNC_STAGES-1];
   assign rise     = sync_out & ~sync_prev;
   // A zero window length behaves as a one-cycle window.
   assign win_load = (win_len == {WINDOW_W{1'b0}}) ? {{(WINDOW_W-1){1'b0}}, 1'b1} : win_len;
   // The edge counter saturates instead of wrapping.
   assign edge_inc = (edge_cnt == {CNT_W{1'b1}}) ? edge_cnt : edge_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   // The slow check wins when min_edges > max_edges.
   assign is_slow  = (edge_cnt < min_lat);
   assign is_fast  = ~is_slow & (edge_cnt > max_lat);

   // Synchronizer chain and the previous-sample flop for edge detection.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync      <= {SYNC_STAGES{1'b0}};
         sync_prev <= 1'b0;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], mon_clk};
         sync_prev <= sync_out;
      end
   end

   // State, window and edge counters, and the configuration latched per window.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= IDLE;
         win_cnt  <= {WINDOW_W{1'b0}};
         edge_cnt <= {CNT_W{1'b0}};
         min_lat  <= {CNT_W{1'b0}};
         max_lat  <= {CNT_W{1'b0}};
      end else begin
         state    <= state_nxt;
         win_cnt  <= win_cnt_nxt;
         edge_cnt <= edge_cnt_nxt;
         if (load_cfg) begin
            min_lat <= min_edges;
            max_lat <= max_edges;
         end
      end
   end

   // Next-state logic. MEASURE runs max(win_len,1) cycles. REPORT lasts one
   // cycle, in which rises are ignored, and then starts the next window.
   always_comb begin
      state_nxt    = state;
      win_cnt_nxt  = win_cnt;
      edge_cnt_nxt = edge_cnt;
      load_cfg     = 1'b0;
      report       = 1'b0;
      case (state)
         IDLE: begin
            win_cnt_nxt  = {WINDOW_W{1'b0}};
            edge_cnt_nxt = {CNT_W{1'b0}};
            if (en) begin
               state_nxt   = MEASURE;
               load_cfg    = 1'b1;
               win_cnt_nxt = win_load;
            end else begin
               state_nxt = IDLE;
            end
         end
         MEASURE: begin
            if (!en) begin
               state_nxt    = IDLE;
               win_cnt_nxt  = {WINDOW_W{1'b0}};
               edge_cnt_nxt = {CNT_W{1'b0}};
            end else begin
               if (rise) begin
                  edge_cnt_nxt = edge_inc;
               end else begin
                  edge_cnt_nxt = edge_cnt;
               end
               if (win_cnt <= {{(WINDOW_W-1){1'b0}}, 1'b1}) begin
                  state_nxt   = REPORT;
                  win_cnt_nxt = {WINDOW_W{1'b0}};
               end else begin
                  state_nxt   = MEASURE;
                  win_cnt_nxt = win_cnt - {{(WINDOW_W-1){1'b0}}, 1'b1};
               end
            end
         end
         REPORT: begin
            edge_cnt_nxt = {CNT_W{1'b0}};
            if (!en) begin
               state_nxt   = IDLE;
               win_cnt_nxt = {WINDOW_W{1'b0}};
            end else begin
               state_nxt   = MEASURE;
               report      = 1'b1;
               load_cfg    = 1'b1;
               win_cnt_nxt = win_load;
            end
         end
         default: begin
            state_nxt    = IDLE;
            win_cnt_nxt  = {WINDOW_W{1'b0}};
            edge_cnt_nxt = {CNT_W{1'b0}};
         end
      endcase
   end

   // Reported result, sticky flags and the interrupt. A set event wins over clear.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         edge_count <= {CNT_W{1'b0}};
         valid      <= 1'b0;
         clk_ok     <= 1'b0;
         slow_err   <= 1'b0;
         fast_err   <= 1'b0;
         irq        <= 1'b0;
      end else begin
         valid    <= report;
         slow_err <= (report & is_slow) | (slow_err & ~clear);
         fast_err <= (report & is_fast) | (fast_err & ~clear);
         irq      <= (slow_err | fast_err | clk_stuck) & ~clear;
         if (report) begin
            edge_count <= edge_cnt;
            clk_ok     <= ~is_slow & ~is_fast;
         end
      end
   end

`ifdef OH_CLKMON_STUCK_EN
   logic [WINDOW_W-1:0] stuck_cnt;

   // Count cycles without a level change on the synchronized clock.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         stuck_cnt <= {WINDOW_W{1'b0}};
      end else if ((state == IDLE) || (sync_out != sync_prev)) begin
         stuck_cnt <= {WINDOW_W{1'b0}};
      end else if (en && (stuck_cnt != {WINDOW_W{1'b1}})) begin
         stuck_cnt <= stuck_cnt + {{(WINDOW_W-1){1'b0}}, 1'b1};
      end
   end

   // Sticky stuck flag. A set event wins over clear.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         clk_stuck <= 1'b0;
      end else begin
         clk_stuck <= (stuck_cnt == {WINDOW_W{1'b1}}) | (clk_stuck & ~clear);
      end
   end
`else
   assign clk_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_oh_clkmon.sv
// Directed testbench for oh_clkmon. Instance a uses the default widths.
// Instance b uses CNT_W=4 to exercise saturation.
module tb_oh_clkmon;

   logic       clk;
   logic       nreset;
   logic       mon_clk;
   int         mon_half;
   logic       mon_level;

   logic       en_a, clear_a;
   logic [7:0] win_len_a, min_a, max_a, edge_count_a;
   logic       valid_a, clk_ok_a, slow_a, fast_a, stuck_a, irq_a;

   logic       en_b, clear_b;
   logic [7:0] win_len_b;
   logic [3:0] min_b, max_b, edge_count_b;
   logic       valid_b, clk_ok_b, slow_b, fast_b, stuck_b, irq_b;

   int n_cmp;
   int n_bad;

   oh_clkmon #(.WINDOW_W(8), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .nreset(nreset), .en(en_a), .mon_clk(mon_clk),
      .win_len(win_len_a), .min_edges(min_a), .max_edges(max_a), .clear(clear_a),
      .edge_count(edge_count_a), .valid(valid_a), .clk_ok(clk_ok_a),
      .slow_err(slow_a), .fast_err(fast_a), .clk_stuck(stuck_a), .irq(irq_a)
   );

   oh_clkmon #(.WINDOW_W(8), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .nreset(nreset), .en(en_b), .mon_clk(mon_clk),
      .win_len(win_len_b), .min_edges(min_b), .max_edges(max_b), .clear(clear_b),
      .edge_count(edge_count_b), .valid(valid_b), .clk_ok(clk_ok_b),
      .slow_err(slow_b), .fast_err(fast_b), .clk_stuck(stuck_b), .irq(irq_b)
   );

   // Reference clock: period 20. Edges fall on even times.
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Monitored clock. All toggles fall on odd times, so they never coincide
   // with a clk edge. A mon_half of 0 holds mon_clk at mon_level.
   initial begin
      mon_clk = 1'b0;
      #1;
      forever begin
         if (mon_half == 0) begin
            mon_clk = mon_level;
            #2;
         end else begin
            #(mon_half);
            mon_clk = ~mon_clk;
         end
      end
   end

   task automatic wait_valid(input bit use_b, input int limit, output int cycles, output bit got);
      cycles = 0;
      got    = 1'b0;
      while (!got && cycles < limit) begin
         @(negedge clk);
         cycles++;
         if ((use_b ? valid_b : valid_a) === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset;
      nreset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (edge_count_a !== 8'd0) begin n_bad++; $display("FAIL reset_edge_count: got %0d expected 0", edge_count_a); end
      n_cmp++; if ({valid_a, clk_ok_a, slow_a, fast_a, stuck_a, irq_a} !== 6'b000000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000000", {valid_a, clk_ok_a, slow_a, fast_a, stuck_a, irq_a}); end
      n_cmp++; if ({edge_count_b, valid_b, irq_b} !== 6'b000000) begin n_bad++; $display("FAIL reset_b: got %b expected 000000", {edge_count_b, valid_b, irq_b}); end
      nreset = 1'b1;
      @(negedge clk);
   endtask

   // Mon period 4 clk, window 64: 16 +/- 1 edges, a valid every 65 cycles.
   task automatic test_ok;
      int cyc; bit got;
      win_len_a = 8'd64; min_a = 8'd14; max_a = 8'd18; mon_half = 40;
      en_a = 1'b1;
      wait_valid(1'b0, 200, cyc, got);
      n_cmp++; if (!got || cyc != 66) begin n_bad++; $display("FAIL ok_first_latency: got %0d cycles (seen=%0d) expected 66", cyc, got); end
      for (int i = 0; i < 3; i++) begin
         wait_valid(1'b0, 100, cyc, got);
         n_cmp++; if (!got || cyc != 65) begin n_bad++; $display("FAIL ok_period: got %0d cycles (seen=%0d) expected 65", cyc, got); end
         n_cmp++; if (edge_count_a < 8'd15 || edge_count_a > 8'd17) begin n_bad++; $display("FAIL ok_count: got %0d expected 15..17", edge_count_a); end
         n_cmp++; if ({clk_ok_a, slow_a, fast_a, irq_a} !== 4'b1000) begin n_bad++; $display("FAIL ok_flags: got %b expected 1000", {clk_ok_a, slow_a, fast_a, irq_a}); end
      end
   endtask

   // Mon period 2.2 clk: about 29 edges, above max -> fast.
   task automatic test_fast;
      int cyc; bit got;
      mon_half = 22;
      wait_valid(1'b0, 100, cyc, got);
      wait_valid(1'b0, 100, cyc, got);
      n_cmp++; if (!got || edge_count_a < 8'd28 || edge_count_a > 8'd30) begin n_bad++; $display("FAIL fast_count: got %0d (seen=%0d) expected 28..30", edge_count_a, got); end
      n_cmp++; if ({clk_ok_a, slow_a, fast_a} !== 3'b001) begin n_bad++; $display("FAIL fast_flags: got %b expected 001", {clk_ok_a, slow_a, fast_a}); end
      // The new window has barely started, so holding mon_clk low now makes it slow.
      mon_half = 0; mon_level = 1'b0;
      @(negedge clk);
      n_cmp++; if (irq_a !== 1'b1) begin n_bad++; $display("FAIL fast_irq: got %b expected 1", irq_a); end
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      n_cmp++; if ({fast_a, irq_a} !== 2'b00) begin n_bad++; $display("FAIL fast_clear: got %b expected 00", {fast_a, irq_a}); end
   endtask

   // mon_clk held low: windows report slow, and clear is overridden by the next set.
   task automatic test_slow;
      int cyc; bit got;
      wait_valid(1'b0, 100, cyc, got);
      n_cmp++; if (!got || {clk_ok_a, slow_a, fast_a} !== 3'b010) begin n_bad++; $display("FAIL slow_first: got %b (seen=%0d) expected 010", {clk_ok_a, slow_a, fast_a}, got); end
      wait_valid(1'b0, 100, cyc, got);
      n_cmp++; if (!got || edge_count_a !== 8'd0) begin n_bad++; $display("FAIL slow_count: got %0d (seen=%0d) expected 0", edge_count_a, got); end
      n_cmp++; if ({clk_ok_a, slow_a} !== 2'b01) begin n_bad++; $display("FAIL slow_flags: got %b expected 01", {clk_ok_a, slow_a}); end
      @(negedge clk);
      n_cmp++; if (irq_a !== 1'b1) begin n_bad++; $display("FAIL slow_irq: got %b expected 1", irq_a); end
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      n_cmp++; if ({slow_a, irq_a} !== 2'b00) begin n_bad++; $display("FAIL slow_clear: got %b expected 00", {slow_a, irq_a}); end
      wait_valid(1'b0, 100, cyc, got);
      n_cmp++; if (!got || slow_a !== 1'b1) begin n_bad++; $display("FAIL slow_reassert: got %b (seen=%0d) expected 1", slow_a, got); end
   endtask

   // en dropped mid-window: no valid, results hold. Re-enable gives a valid after W+2 cycles.
   task automatic test_en_drop;
      int cyc; bit got; int seen; logic [7:0] held;
      mon_half = 40;
      wait_valid(1'b0, 100, cyc, got);
      wait_valid(1'b0, 100, cyc, got);
      n_cmp++; if (!got || clk_ok_a !== 1'b1) begin n_bad++; $display("FAIL drop_pre_ok: got %b (seen=%0d) expected 1", clk_ok_a, got); end
      held = edge_count_a;
      repeat (20) @(negedge clk);
      en_a = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (valid_a === 1'b1) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL drop_no_valid: got %0d pulses expected 0", seen); end
      n_cmp++; if (edge_count_a !== held || clk_ok_a !== 1'b1) begin n_bad++; $display("FAIL drop_hold: got %0d/%b expected %0d/1", edge_count_a, clk_ok_a, held); end
      en_a = 1'b1;
      wait_valid(1'b0, 200, cyc, got);
      n_cmp++; if (!got || cyc != 66) begin n_bad++; $display("FAIL drop_restart: got %0d cycles (seen=%0d) expected 66", cyc, got); end
   endtask

   // win_len changed mid-window only applies to the next window. A zero length gives period 2.
   task automatic test_win0;
      int cyc; bit got;
      win_len_a = 8'd0;
      wait_valid(1'b0, 100, cyc, got);
      n_cmp++; if (!got || cyc != 65) begin n_bad++; $display("FAIL win0_deferred: got %0d cycles (seen=%0d) expected 65", cyc, got); end
      for (int i = 0; i < 2; i++) begin
         wait_valid(1'b0, 10, cyc, got);
         n_cmp++; if (!got || cyc != 2) begin n_bad++; $display("FAIL win0_period: got %0d cycles (seen=%0d) expected 2", cyc, got); end
      end
   endtask

   // CNT_W=4, mon period 3 clk, window 60: about 20 edges saturates at 15.
   task automatic test_saturate;
      int cyc; bit got;
      en_a = 1'b0;
      win_len_b = 8'd60; min_b = 4'd0; max_b = 4'd15; mon_half = 30;
      en_b = 1'b1;
      wait_valid(1'b1, 200, cyc, got);
      n_cmp++; if (!got || cyc != 62) begin n_bad++; $display("FAIL sat_latency: got %0d cycles (seen=%0d) expected 62", cyc, got); end
      wait_valid(1'b1, 100, cyc, got);
      n_cmp++; if (!got || edge_count_b !== 4'd15) begin n_bad++; $display("FAIL sat_count: got %0d (seen=%0d) expected 15", edge_count_b, got); end
      n_cmp++; if ({clk_ok_b, slow_b, fast_b} !== 3'b100) begin n_bad++; $display("FAIL sat_flags: got %b expected 100", {clk_ok_b, slow_b, fast_b}); end
      en_b = 1'b0;
   endtask

   // mon_clk held high with the monitor enabled.
   task automatic test_stuck;
      logic exp_stuck;
`ifdef OH_CLKMON_STUCK_EN
      exp_stuck = 1'b1;
`else
      exp_stuck = 1'b0;
`endif
      win_len_a = 8'd64; mon_half = 0; mon_level = 1'b1;
      en_a = 1'b1;
      repeat (300) @(negedge clk);
      n_cmp++; if (stuck_a !== exp_stuck) begin n_bad++; $display("FAIL stuck_flag: got %b expected %b", stuck_a, exp_stuck); end
      n_cmp++; if (stuck_b !== 1'b0) begin n_bad++; $display("FAIL stuck_idle_b: got %b expected 0", stuck_b); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      mon_half = 40; mon_level = 1'b0;
      en_a = 1'b0; clear_a = 1'b0; win_len_a = 8'd64; min_a = 8'd14; max_a = 8'd18;
      en_b = 1'b0; clear_b = 1'b0; win_len_b = 8'd60; min_b = 4'd0; max_b = 4'd15;
      nreset = 1'b0;
      test_reset();
      test_ok();
      test_fast();
      test_slow();
      test_en_drop();
      test_win0();
      test_saturate();
      test_stuck();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
